// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides clk into quarter-frame ticks, drives 240/120 Hz strobes in 4/5-step modes.
// Optional macro FRAME_IRQ_EN enables the sticky frame IRQ; when undefined frame_irq is tied to 0.
module frame_sequencer #(
    parameter int unsigned QUARTER_PERIOD = 7457,
    parameter int unsigned PRESCALE_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_4017,
    input  logic       reg_change,
    input  logic       irq_clear,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq,
    output logic [2:0] step
);
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(QUARTER_PERIOD - 1);

    typedef enum logic [2:0] {
        STEP0 = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4
    } step_e;

    step_e                 step_q, step_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  mode_q, mode_d;
    logic                  sync1_q, sync2_q, wr_stb_q;
    logic                  en240_d, en120_d;
    logic                  tick_c;
    logic                  irq_set_c;

    // State register: sync chain, write strobe, prescaler, step, mode and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            wr_stb_q     <= 1'b0;
            prescale_q   <= '0;
            step_q       <= STEP0;
            mode_q       <= 1'b0;
            enable_240hz <= 1'b0;
            enable_120hz <= 1'b0;
        end else begin
            sync1_q      <= reg_change;
            sync2_q      <= sync1_q;
            wr_stb_q     <= sync1_q ^ sync2_q;
            prescale_q   <= prescale_d;
            step_q       <= step_d;
            mode_q       <= mode_d;
            enable_240hz <= en240_d;
            enable_120hz <= en120_d;
        end
    end

    // Next state: a register write restarts the sequence and overrides a coincident tick
    always_comb begin
        tick_c     = (prescale_q == PRESCALE_LAST);
        prescale_d = tick_c ? '0 : prescale_q + PRESCALE_W'(1);
        step_d     = step_q;
        mode_d     = mode_q;
        en240_d    = 1'b0;
        en120_d    = 1'b0;
        if (wr_stb_q) begin
            mode_d     = reg_4017[7];
            prescale_d = '0;
            step_d     = STEP0;
            en240_d    = reg_4017[7];
            en120_d    = reg_4017[7];
        end else if (tick_c) begin
            case (step_q)
                STEP0: begin
                    en240_d = 1'b1;
                    step_d  = STEP1;
                end
                STEP1: begin
                    en240_d = 1'b1;
                    en120_d = 1'b1;
                    step_d  = STEP2;
                end
                STEP2: begin
                    en240_d = 1'b1;
                    step_d  = STEP3;
                end
                STEP3: begin
                    if (mode_q) begin
                        step_d = STEP4;
                    end else begin
                        en240_d = 1'b1;
                        en120_d = 1'b1;
                        step_d  = STEP0;
                    end
                end
                STEP4: begin
                    en240_d = 1'b1;
                    en120_d = 1'b1;
                    step_d  = STEP0;
                end
                default: step_d = STEP0;
            endcase
        end
    end

    assign irq_set_c = tick_c && !wr_stb_q && !mode_q && (step_q == STEP3);
    assign step      = step_q;

`ifdef FRAME_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic unused_bits;

    // IRQ flag: set beats irq_clear; an inhibiting write always clears
    always_comb begin
        inhibit_d = inhibit_q;
        irq_d     = irq_q;
        if (wr_stb_q) begin
            inhibit_d = reg_4017[6];
            if (reg_4017[6] || irq_clear) begin
                irq_d = 1'b0;
            end
        end else if (irq_set_c && !inhibit_q) begin
            irq_d = 1'b1;
        end else if (irq_clear) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
        end
    end

    assign frame_irq   = irq_q;
    assign unused_bits = ^reg_4017[5:0];
`else
    logic unused_bits;

    assign frame_irq   = 1'b0;
    assign unused_bits = ^{reg_4017[6:0], irq_clear, irq_set_c};
`endif

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Upstream APU timing source for the pulse, triangle and noise channels.
- Divides the system clock into quarter-frame ticks and drives one-cycle `enable_240hz` and `enable_120hz` strobes.
- Supports two modes, 4-step and 5-step, plus a frame IRQ.
- Takes its configuration from register 0x4017, delivered through the same toggle-style clock-crossing handshake the channels use.

Parameters:
- QUARTER_PERIOD, 7457, clk cycles per quarter-frame step (1.79 MHz / 240 Hz); legal range 2..65535.
- PRESCALE_W, 16, width of the prescaler counter; must hold QUARTER_PERIOD-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- reg_4017  input  8  frame config: [7]=mode (0: 4-step, 1: 5-step), [6]=irq_inhibit, others ignored
- reg_change  input  1  toggle from the register clock domain; every edge marks a new reg_4017 write
- irq_clear  input  1  single-cycle synchronous pulse that clears frame_irq (status read)
- enable_240hz  output  1  one-cycle quarter-frame strobe (envelope)
- enable_120hz  output  1  one-cycle half-frame strobe (length, sweep)
- frame_irq  output  1  sticky frame interrupt flag
- step  output  3  current sequencer step, 0..4

Behaviour:
- Reset (rst_n low, async):
  - all state 0: prescaler, step, mode, irq_inhibit, sync flops, strobes, frame_irq.
  - Reset mode is 4-step with IRQ not inhibited.
- Write detect:
  - reg_change passes through 2 sync flops; a write strobe is registered when the 2 flops differ.
  - reg_4017 is sampled on the write strobe cycle; it is quasi-static by then.
  - Because sync flops reset to 0, reg_change held high at reset release produces one write. This is intended.
- On write strobe:
  - latch mode and irq_inhibit; prescaler <= 0; step <= 0.
  - If irq_inhibit=1, frame_irq <= 0 in the same cycle.
  - If new mode = 5-step, enable_240hz and enable_120hz pulse together on the following cycle (immediate clock).
  - If new mode = 4-step, no immediate strobe.
- Prescaler:
  - counts 0..QUARTER_PERIOD-1 and wraps to 0.
  - The wrap cycle is an internal tick.
- On each tick, step advances; strobes are registered and appear 1 cycle after the tick:
  - 4-step: step0: 240. step1: 240+120. step2: 240. step3: 240+120, and frame_irq <= 1 if !irq_inhibit. Then step wraps 3->0.
  - 5-step: step0: 240. step1: 240+120. step2: 240. step3: none. step4: 240+120. Then step wraps 4->0. No IRQ is ever set in 5-step.
- Strobe timing:
  - Strobes are exactly 1 cycle wide.
  - enable_120hz never asserts without enable_240hz.
- frame_irq:
  - set by the 4-step step3 tick; cleared by irq_clear or by a write with irq_inhibit=1.
  - Set and clear in the same cycle: set wins.
  - Remains set across a mode change to 5-step until it is cleared.
- Simultaneous write strobe and tick: the write wins; that tick's strobes and IRQ are discarded.
- Reset asserted mid-step: all outputs drop asynchronously. The sequence restarts from step 0, prescaler 0, after release.
- Arithmetic:
  - prescaler is unsigned PRESCALE_W bits; step is 3 bits.
  - No counter reaches its natural overflow; wrap is explicit.

Optional Feature:
- Macro: FRAME_IRQ_EN.
- Defined: frame_irq logic is as described above.
- Undefined:
  - frame_irq is constant 0, and irq_clear and reg_4017[6] are ignored.
  - No IRQ flop is synthesised.
  - The port list is unchanged.

Test Plan:
- QUARTER_PERIOD=4, reset then idle 40 cycles:
  - enable_240hz pulses every 4 cycles, 1 cycle wide.
  - enable_120hz accompanies the 2nd and 4th of every 4 pulses.
  - frame_irq rises together with the 4th enable_240hz and stays high.
- Same run, pulse irq_clear:
  - frame_irq falls the next cycle.
  - It re-rises at the next step3 tick.
  - irq_clear issued on the exact set cycle leaves frame_irq=1.
- Write reg_4017=0x80 (toggle reg_change):
  - about 3 cycles later, enable_240hz and enable_120hz pulse together.
  - Then the 5-step pattern 240, 240+120, 240, none, 240+120 repeats every 20 cycles.
  - frame_irq stays 0.
- Write reg_4017=0x40 while frame_irq=1: frame_irq clears when the write strobe occurs; no further IRQ in 4-step.
- Toggle reg_change so the write strobe lands on a tick cycle: no strobe from that tick, and step and prescaler restart at 0.
- Assert rst_n low mid-step for 1 cycle: all outputs are 0 immediately, and the first enable_240hz comes 4 cycles after release.
- Build without FRAME_IRQ_EN and rerun scenario 1: frame_irq is constantly 0 and the strobes are unchanged.
